// File: rtl/regfile_inexrecur_q_if.sv
// Request/response bundle for the inexact-recursion state register file.
// The master side (recursion controller / backtrack stage) drives requests;
// the slave side (the register file) returns read data, occupancy and status.
interface regfile_inexrecur_q_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic              clr;
    logic              we;
    logic [DATA_W-1:0] w_data;
    logic              seq_re;
    logic              ran_re;
    logic [ADDR_W-1:0] ran_r_addr;
    logic              out_valid;
    logic [DATA_W-1:0] out_r_data;
    logic [ADDR_W-1:0] out_r_addr;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              ovf;
    logic              udf;
    logic              rerr;

    modport master (
        output clr, we, w_data, seq_re, ran_re, ran_r_addr,
        input  out_valid, out_r_data, out_r_addr, count, empty, full, ovf, udf, rerr
    );

    modport slave (
        input  clr, we, w_data, seq_re, ran_re, ran_r_addr,
        output out_valid, out_r_data, out_r_addr, count, empty, full, ovf, udf, rerr
    );
endinterface

// File: rtl/regfile_inexrecur_q.sv
// DEPTH-entry store of packed recursion-state words. Sequential consume port in
// FIFO or LIFO order, non-destructive random-read port, occupancy tracking and
// one-cycle error pulses. Read data is registered (1-cycle latency).
module regfile_inexrecur_q #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096,
    parameter int LIFO   = 0
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_inexrecur_q_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam bit                IS_LIFO  = (LIFO != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   cnt;

    logic [ADDR_W-1:0] wr_ptr_inc, rd_ptr_inc, top_ptr, seq_addr, rd_addr, wr_addr;
    logic              seq_ok, wr_ok, ran_in_range, ran_ok, ran_bad, seq_bad, wr_bad;

    // Accept/reject decisions and address selection for this cycle.
    always_comb begin
        wr_ptr_inc   = (wr_ptr == LAST) ? '0 : wr_ptr + ADDR_W'(1);
        rd_ptr_inc   = (rd_ptr == LAST) ? '0 : rd_ptr + ADDR_W'(1);
        // Top of stack is the slot just below wr_ptr, wrapping when full.
        top_ptr      = (wr_ptr == '0) ? LAST : wr_ptr - ADDR_W'(1);
        seq_addr     = IS_LIFO ? top_ptr : rd_ptr;
        seq_ok       = !bus.clr && bus.seq_re && (cnt != '0);
        seq_bad      = !bus.clr && bus.seq_re && (cnt == '0);
        // A same-cycle accepted read frees a slot, so a full store still takes the write.
        wr_ok        = !bus.clr && bus.we && ((cnt != FULL_CNT) || seq_ok);
        wr_bad       = !bus.clr && bus.we && (cnt == FULL_CNT) && !seq_ok;
        // Random reads only win the read port when no sequential read is asked for.
        ran_in_range = ({1'b0, bus.ran_r_addr} < FULL_CNT);
        ran_ok       = !bus.clr && bus.ran_re && !bus.seq_re && ran_in_range;
        ran_bad      = !bus.clr && bus.ran_re && !bus.seq_re && !ran_in_range;
        rd_addr      = seq_ok ? seq_addr : bus.ran_r_addr;
        // LIFO push+pop is a replace of the current top.
        wr_addr      = (IS_LIFO && seq_ok) ? top_ptr : wr_ptr;
    end

    // Storage array; no reset so contents survive clr, writes blocked while in reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) mem[wr_addr] <= bus.w_data;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (bus.clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (IS_LIFO) begin
                if (wr_ok && !seq_ok)      wr_ptr <= wr_ptr_inc;
                else if (seq_ok && !wr_ok) wr_ptr <= top_ptr;
            end else begin
                if (wr_ok)  wr_ptr <= wr_ptr_inc;
                if (seq_ok) rd_ptr <= rd_ptr_inc;
            end
            if (wr_ok && !seq_ok)      cnt <= cnt + (ADDR_W + 1)'(1);
            else if (seq_ok && !wr_ok) cnt <= cnt - (ADDR_W + 1)'(1);
        end
    end

    // Registered read port and one-cycle status pulses; data/addr hold between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.out_r_data <= '0;
            bus.out_r_addr <= '0;
            bus.ovf        <= 1'b0;
            bus.udf        <= 1'b0;
            bus.rerr       <= 1'b0;
        end else begin
            bus.out_valid <= seq_ok || ran_ok;
            bus.ovf       <= wr_bad;
            bus.udf       <= seq_bad;
            bus.rerr      <= ran_bad;
            if (seq_ok || ran_ok) begin
                bus.out_r_data <= mem[rd_addr];
                bus.out_r_addr <= rd_addr;
            end
        end
    end

    assign bus.count = cnt;
    assign bus.empty = (cnt == '0);
    assign bus.full  = (cnt == FULL_CNT);
endmodule

// File: tb/tb_regfile_inexrecur_q.sv
// Bench for regfile_inexrecur_q: one FIFO and one LIFO instance (DEPTH=4),
// driven from a step table; read results checked through a scoreboard queue.
module tb_regfile_inexrecur_q;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_inexrecur_q_if #(.DATA_W(DW), .ADDR_W(AW)) fbus ();
    regfile_inexrecur_q_if #(.DATA_W(DW), .ADDR_W(AW)) lbus ();

    regfile_inexrecur_q #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .LIFO(0)) u_fifo (
        .clk(clk), .rst_n(rst_n), .bus(fbus.slave));
    regfile_inexrecur_q #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .LIFO(1)) u_lifo (
        .clk(clk), .rst_n(rst_n), .bus(lbus.slave));

    // Per-instance drive variables (index 0 = FIFO, 1 = LIFO)
    logic          i_clr[2], i_we[2], i_seq[2], i_ran[2];
    logic [DW-1:0] i_wd[2];
    logic [AW-1:0] i_ra[2];
    logic          o_vld[2], o_empty[2], o_full[2], o_ovf[2], o_udf[2], o_rerr[2];
    logic [DW-1:0] o_data[2];
    logic [AW-1:0] o_addr[2];
    logic [AW:0]   o_cnt[2];

    assign fbus.clr = i_clr[0]; assign fbus.we = i_we[0]; assign fbus.w_data = i_wd[0];
    assign fbus.seq_re = i_seq[0]; assign fbus.ran_re = i_ran[0]; assign fbus.ran_r_addr = i_ra[0];
    assign lbus.clr = i_clr[1]; assign lbus.we = i_we[1]; assign lbus.w_data = i_wd[1];
    assign lbus.seq_re = i_seq[1]; assign lbus.ran_re = i_ran[1]; assign lbus.ran_r_addr = i_ra[1];
    assign o_vld[0] = fbus.out_valid; assign o_data[0] = fbus.out_r_data; assign o_addr[0] = fbus.out_r_addr;
    assign o_cnt[0] = fbus.count; assign o_empty[0] = fbus.empty; assign o_full[0] = fbus.full;
    assign o_ovf[0] = fbus.ovf; assign o_udf[0] = fbus.udf; assign o_rerr[0] = fbus.rerr;
    assign o_vld[1] = lbus.out_valid; assign o_data[1] = lbus.out_r_data; assign o_addr[1] = lbus.out_r_addr;
    assign o_cnt[1] = lbus.count; assign o_empty[1] = lbus.empty; assign o_full[1] = lbus.full;
    assign o_ovf[1] = lbus.ovf; assign o_udf[1] = lbus.udf; assign o_rerr[1] = lbus.rerr;

    typedef struct {
        int            dut;
        logic          clr, we, seq, ran;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra;
        logic          ev, eo, eu, er;
        logic [DW-1:0] ed;
        logic [AW-1:0] ea;
        logic [AW:0]   ec;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
    } exp_t;

    vec_t          tbl[$];
    exp_t          sbq0[$], sbq1[$];
    logic [DW-1:0] last_d[2];
    logic [AW-1:0] last_a[2];
    int            checks = 0;
    int            errors = 0;

    function automatic vec_t mk(int dut, logic clr, logic we, logic [DW-1:0] wd, logic seq,
                                logic ran, logic [AW-1:0] ra, logic ev, logic [DW-1:0] ed,
                                logic [AW-1:0] ea, logic eo, logic eu, logic er, logic [AW:0] ec);
        vec_t v;
        v.dut = dut; v.clr = clr; v.we = we; v.wd = wd; v.seq = seq; v.ran = ran; v.ra = ra;
        v.ev = ev; v.ed = ed; v.ea = ea; v.eo = eo; v.eu = eu; v.er = er; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input int step, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h want %0h", name, step, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            i_clr[d] = 0; i_we[d] = 0; i_seq[d] = 0; i_ran[d] = 0; i_wd[d] = '0; i_ra[d] = '0;
        end
    endtask

    task automatic run_step(input vec_t v, input int step);
        exp_t e;
        int   d;
        d = v.dut;
        @(negedge clk);
        i_clr[d] = v.clr; i_we[d] = v.we; i_wd[d] = v.wd;
        i_seq[d] = v.seq; i_ran[d] = v.ran; i_ra[d] = v.ra;
        if (v.ev) begin
            e.d = v.ed; e.a = v.ea;
            if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
        end
        @(posedge clk);
        #1;
        idle_all();
        chk("out_valid", step, DW'(o_vld[d]), DW'(v.ev));
        chk("ovf", step, DW'(o_ovf[d]), DW'(v.eo));
        chk("udf", step, DW'(o_udf[d]), DW'(v.eu));
        chk("rerr", step, DW'(o_rerr[d]), DW'(v.er));
        chk("count", step, DW'(o_cnt[d]), DW'(v.ec));
        chk("empty", step, DW'(o_empty[d]), DW'(v.ec == 0));
        chk("full", step, DW'(o_full[d]), DW'(v.ec == (AW+1)'(DP)));
        if (o_vld[d]) begin
            if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
                checks++; errors++;
                $display("FAIL scoreboard step %0d: unexpected out_valid, data %0h", step, o_data[d]);
            end else begin
                e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
                chk("out_r_data", step, o_data[d], e.d);
                chk("out_r_addr", step, DW'(o_addr[d]), DW'(e.a));
                last_d[d] = e.d; last_a[d] = e.a;
            end
        end else begin
            chk("data_hold", step, o_data[d], last_d[d]);
            chk("addr_hold", step, DW'(o_addr[d]), DW'(last_a[d]));
        end
    endtask

    initial begin
        idle_all();
        last_d[0] = '0; last_d[1] = '0; last_a[0] = '0; last_a[1] = '0;

        // FIFO: in-order reads, clear, full/ovf, simultaneous access, random reads, empty corners
        tbl.push_back(mk(0, 0,0,32'h0,        1,0,0, 0,32'h0,0,        0,1,0, 0));
        tbl.push_back(mk(0, 0,1,32'h02010006, 0,0,0, 0,32'h0,0,        0,0,0, 1));
        tbl.push_back(mk(0, 0,1,32'h01000006, 0,0,0, 0,32'h0,0,        0,0,0, 2));
        tbl.push_back(mk(0, 0,1,32'h02000606, 0,0,0, 0,32'h0,0,        0,0,0, 3));
        tbl.push_back(mk(0, 0,0,32'h0,        0,1,2, 1,32'h02000606,2, 0,0,0, 3));
        tbl.push_back(mk(0, 0,0,32'h0,        0,1,1, 1,32'h01000006,1, 0,0,0, 3));
        tbl.push_back(mk(0, 0,0,32'h0,        0,1,0, 1,32'h02010006,0, 0,0,0, 3));
        tbl.push_back(mk(0, 0,0,32'h0,        1,0,0, 1,32'h02010006,0, 0,0,0, 2));
        tbl.push_back(mk(0, 0,0,32'h0,        1,0,0, 1,32'h01000006,1, 0,0,0, 1));
        tbl.push_back(mk(0, 0,0,32'h0,        1,0,0, 1,32'h02000606,2, 0,0,0, 0));
        tbl.push_back(mk(0, 1,0,32'h0,        0,0,0, 0,32'h0,0,        0,0,0, 0));
        tbl.push_back(mk(0, 0,1,32'h10,       0,0,0, 0,32'h0,0,        0,0,0, 1));
        tbl.push_back(mk(0, 0,1,32'h11,       0,0,0, 0,32'h0,0,        0,0,0, 2));
        tbl.push_back(mk(0, 0,1,32'h12,       0,0,0, 0,32'h0,0,        0,0,0, 3));
        tbl.push_back(mk(0, 0,1,32'h13,       0,0,0, 0,32'h0,0,        0,0,0, 4));
        tbl.push_back(mk(0, 0,1,32'h14,       0,0,0, 0,32'h0,0,        1,0,0, 4));
        tbl.push_back(mk(0, 0,1,32'h15,       1,0,0, 1,32'h10,0,       0,0,0, 4));
        tbl.push_back(mk(0, 0,0,32'h0,        0,1,0, 1,32'h15,0,       0,0,0, 4));
        tbl.push_back(mk(0, 0,0,32'h0,        0,1,3, 1,32'h13,3,       0,0,0, 4));
        tbl.push_back(mk(0, 0,0,32'h0,        0,1,4, 0,32'h0,0,        0,0,1, 4));
        tbl.push_back(mk(0, 0,0,32'h0,        1,1,3, 1,32'h11,1,       0,0,0, 3));
        tbl.push_back(mk(0, 0,0,32'h0,        1,1,6, 1,32'h12,2,       0,0,0, 2));
        tbl.push_back(mk(0, 1,1,32'h99,       1,1,0, 0,32'h0,0,        0,0,0, 0));
        tbl.push_back(mk(0, 0,0,32'h0,        1,0,0, 0,32'h0,0,        0,1,0, 0));
        tbl.push_back(mk(0, 0,1,32'h20,       1,0,0, 0,32'h0,0,        0,1,0, 1));
        tbl.push_back(mk(0, 0,0,32'h0,        1,0,0, 1,32'h20,0,       0,0,0, 0));
        // LIFO: stack order, replace on push+pop, underflow, wrap of the top pointer
        tbl.push_back(mk(1, 0,0,32'h0,        1,0,0, 0,32'h0,0,        0,1,0, 0));
        tbl.push_back(mk(1, 0,1,32'hA,        0,0,0, 0,32'h0,0,        0,0,0, 1));
        tbl.push_back(mk(1, 0,1,32'hB,        0,0,0, 0,32'h0,0,        0,0,0, 2));
        tbl.push_back(mk(1, 0,1,32'hC,        0,0,0, 0,32'h0,0,        0,0,0, 3));
        tbl.push_back(mk(1, 0,0,32'h0,        1,0,0, 1,32'hC,2,        0,0,0, 2));
        tbl.push_back(mk(1, 0,1,32'hD,        1,0,0, 1,32'hB,1,        0,0,0, 2));
        tbl.push_back(mk(1, 0,0,32'h0,        1,0,0, 1,32'hD,1,        0,0,0, 1));
        tbl.push_back(mk(1, 0,0,32'h0,        1,0,0, 1,32'hA,0,        0,0,0, 0));
        tbl.push_back(mk(1, 0,0,32'h0,        1,0,0, 0,32'h0,0,        0,1,0, 0));
        tbl.push_back(mk(1, 0,1,32'hE,        1,0,0, 0,32'h0,0,        0,1,0, 1));
        tbl.push_back(mk(1, 0,0,32'h0,        0,1,0, 1,32'hE,0,        0,0,0, 1));
        tbl.push_back(mk(1, 0,1,32'hF,        0,0,0, 0,32'h0,0,        0,0,0, 2));
        tbl.push_back(mk(1, 0,1,32'h1F,       0,0,0, 0,32'h0,0,        0,0,0, 3));
        tbl.push_back(mk(1, 0,1,32'h2F,       0,0,0, 0,32'h0,0,        0,0,0, 4));
        tbl.push_back(mk(1, 0,1,32'h3F,       0,0,0, 0,32'h0,0,        1,0,0, 4));
        tbl.push_back(mk(1, 0,1,32'h4F,       1,0,0, 1,32'h2F,3,       0,0,0, 4));
        tbl.push_back(mk(1, 0,0,32'h0,        1,0,0, 1,32'h4F,3,       0,0,0, 3));
        tbl.push_back(mk(1, 0,0,32'h0,        1,0,0, 1,32'h1F,2,       0,0,0, 2));

        // Reset state, checked while reset is held and after release
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("rst_count", d, DW'(o_cnt[d]), 0);
            chk("rst_empty", d, DW'(o_empty[d]), 1);
            chk("rst_valid", d, DW'(o_vld[d]), 0);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_data", d, o_data[d], '0);
            chk("rst_full", d, DW'(o_full[d]), 0);
        end

        foreach (tbl[k]) run_step(tbl[k], k);

        chk("sbq_fifo_left", 100, DW'(sbq0.size()), 0);
        chk("sbq_lifo_left", 101, DW'(sbq1.size()), 0);

        // Asynchronous reset mid-burst: outputs return to reset values before the next edge
        @(negedge clk);
        i_we[0] = 1; i_wd[0] = 32'h77;
        @(negedge clk);
        i_we[0] = 1; i_wd[0] = 32'h88; i_seq[0] = 1;
        @(posedge clk);
        #1;
        chk("burst_valid", 200, DW'(o_vld[0]), 1);
        chk("burst_data", 200, o_data[0], 32'h77);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 201, DW'(o_vld[0]), 0);
        chk("arst_data", 201, o_data[0], '0);
        chk("arst_addr", 201, DW'(o_addr[0]), 0);
        chk("arst_count", 201, DW'(o_cnt[0]), 0);
        chk("arst_empty", 201, DW'(o_empty[0]), 1);
        @(posedge clk);
        #1;
        chk("arst_hold_count", 202, DW'(o_cnt[0]), 0);
        @(negedge clk);
        idle_all();
        rst_n = 1'b1;
        @(negedge clk);
        i_seq[0] = 1;
        @(posedge clk);
        #1;
        chk("post_rst_udf", 203, DW'(o_udf[0]), 1);
        chk("post_rst_valid", 203, DW'(o_vld[0]), 0);
        idle_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running want finished");
        $fatal(1);
    end
endmodule

// File: doc/regfile_inexrecur_q.md
# regfile_inexrecur_q

Parametrised successor to the inexact-recursion register file: a DEPTH-entry store of packed recursion-state words with a write port, a sequential consume port (FIFO or LIFO order, chosen by parameter) and a non-destructive random-read port. Sits between the inexact-recursion controller, which pushes candidate states, and the backtracking/output stage, which consumes them. Adds to the previous generation: configurable width/depth/order, circular pointers, occupancy count, full/empty flags, overflow/underflow reporting, synchronous clear and defined simultaneous-access behaviour.

## Interface
- DATA_W, 32, width of one packed state word
- ADDR_W, 12, address width; DEPTH must be ≤ 2**ADDR_W
- DEPTH, 4096, number of entries (≥2)
- LIFO, 0, 0 = sequential reads in FIFO order, 1 = stack order (pop from top)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of pointers/count/flags (storage contents untouched)
- we  in  1  write (push) request
- w_data  in  DATA_W  word to write
- seq_re  in  1  sequential (consuming) read request
- ran_re  in  1  random (non-consuming) read request
- ran_r_addr  in  ADDR_W  physical entry index for random read
- out_valid  out  1  one-cycle pulse: out_r_data/out_r_addr updated this cycle
- out_r_data  out  DATA_W  read data
- out_r_addr  out  ADDR_W  physical index the data came from
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- ovf  out  1  one-cycle pulse: write rejected (full)
- udf  out  1  one-cycle pulse: sequential read rejected (empty)
- rerr  out  1  one-cycle pulse: random read rejected (ran_r_addr ≥ DEPTH)

## Operation
- Storage mem[0..DEPTH-1]; wr_ptr, rd_ptr wrap DEPTH-1 → 0 (non-power-of-two DEPTH supported).
- FIFO (LIFO=0): write stores at wr_ptr, wr_ptr++; seq read returns mem[rd_ptr], rd_ptr++.
- LIFO (LIFO=1): rd_ptr fixed at 0; write stores at wr_ptr, wr_ptr++; seq read returns mem[wr_ptr-1], wr_ptr--.
- Random read returns mem[ran_r_addr]; pointers and count unchanged; reading unoccupied slots is legal (returns stale contents).
- Read-port priority: seq_re over ran_re; when both asserted, random request is dropped silently (no rerr).
- Write while full and no accepted seq read: ignored, ovf pulses. Seq read while empty: ignored, udf pulses, out_valid stays 0.
- Simultaneous we & seq_re, FIFO: both accepted whenever count>0 (including full); count unchanged. If empty: write accepted, read rejected with udf.
- Simultaneous we & seq_re, LIFO, count>0: replace — out_r_data = old top mem[wr_ptr-1], mem[wr_ptr-1] ← w_data, wr_ptr/count unchanged. If empty: push accepted, udf.
- clr: wr_ptr=rd_ptr=count=0, all pulses 0 that cycle, any same-cycle we/seq_re/ran_re ignored; out_r_data/out_r_addr keep their values.

## Timing
- Reset (async, rst_n=0): wr_ptr, rd_ptr, count=0; empty=1; full, out_valid, ovf, udf, rerr=0; out_r_data=0, out_r_addr=0.
- Write: visible in count/empty/full on the next edge; data readable by a request issued the following cycle.
- Read latency 1 cycle: request sampled at edge N, out_valid=1 with data/addr after edge N (registered outputs); out_r_data/out_r_addr hold between reads.
- Back-to-back reads every cycle supported; out_valid can be high continuously.
- Error pulses asserted exactly one cycle, aligned with the cycle out_valid would have been.
- rst_n deasserted mid-operation: state restarts empty; no partial write completes.

## Test plan
- FIFO, DATA_W=32, DEPTH=4: write 0x02010006, 0x01000006, 0x02000606; three seq reads → out_valid pulses with data in that order, addr 0,1,2; then empty=1, count=0.
- FIFO wrap/full: 4 writes → full=1, count=4; 5th write → ovf pulse, contents unchanged; we&seq_re together while full → read returns entry 0, write lands at index 0, count stays 4.
- LIFO, DEPTH=4: push A,B,C; seq read → C (addr 2); we=D & seq_re together → out B, top replaced by D; next pop → D then A; extra pop → udf pulse, out_valid=0.
- Random read: after 3 writes, ran_re with addr 2,1,0 → data at those indices, count unchanged; addr 4 (≥DEPTH) → rerr pulse, no out_valid; seq_re&ran_re same cycle → only sequential result.
- Empty read: seq_re on fresh reset → udf pulse, outputs remain 0; we&seq_re while empty → write accepted (count=1), udf pulse.
- Clear/reset: after 3 writes assert clr with we=1 → count=0, empty=1, no write; assert rst_n=0 asynchronously mid-burst → all outputs to reset values before next clock edge.
